// File: rtl/mvm_drv_pkg.sv
// Shared types and default widths for the matrix-vector engine host driver.
package mvm_drv_pkg;

  localparam int IWIDTH_D     = 8;
  localparam int OWIDTH_D     = 32;
  localparam int NUM_OLANES_D = 8;
  localparam int VEC_ADDRW_D  = 8;
  localparam int MAT_ADDRW_D  = 9;
  localparam int RES_DEPTH_D  = 4;
  localparam int MEM_DATAW_D  = IWIDTH_D * 8;
  localparam int LANE_W_D     = $clog2(NUM_OLANES_D);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_VEC,
    S_LOAD_MAT,
    S_KICK,
    S_RUN
  } state_e;

  typedef logic [NUM_OLANES_D-1:0][OWIDTH_D-1:0] res_set_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mvm_drv_resbuf.sv
// Result-set FIFO; a push into a full buffer is dropped unless a pop frees a slot that cycle.
module mvm_drv_resbuf
  import mvm_drv_pkg::*;
#(
  parameter int  DEPTH = RES_DEPTH_D,
  parameter type set_t = res_set_t
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  set_t push_data_i,
  input  logic pop_i,
  output set_t head_o,
  output logic full_o,
  output logic empty_o,
  output logic drop_o
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_q, rd_q;
  set_t        mem_q [DEPTH];
  logic        pop_ok, push_ok;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && !push_ok;
  assign head_o  = mem_q[rd_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[PW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/mvm_driver.sv
// Host-side initiator: loads engine memories from a stream, kicks a run, drains results.
// Optional MVM_DRV_PERF_EN adds a perf_cycles run-latency counter.
module mvm_driver
  import mvm_drv_pkg::*;
#(
  parameter int IWIDTH     = 8,
  parameter int OWIDTH     = 32,
  parameter int MEM_DATAW  = IWIDTH * 8,
  parameter int VEC_ADDRW  = 8,
  parameter int MAT_ADDRW  = 9,
  parameter int NUM_OLANES = 8,
  parameter int RES_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [VEC_ADDRW:0]            cfg_vec_words,
  input  logic [MAT_ADDRW:0]            cfg_mat_rows,
  output logic                          cfg_err,
  input  logic [MEM_DATAW-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [OWIDTH-1:0]             m_result,
  output logic [$clog2(NUM_OLANES)-1:0] m_lane,
  output logic                          m_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [MEM_DATAW-1:0]          vec_wdata,
  output logic [VEC_ADDRW-1:0]          vec_waddr,
  output logic                          vec_wen,
  output logic [MEM_DATAW-1:0]          mat_wdata,
  output logic [MAT_ADDRW-1:0]          mat_waddr,
  output logic [NUM_OLANES-1:0]         mat_wen,
  output logic                          mvm_start,
  output logic [VEC_ADDRW-1:0]          mvm_vec_start_addr,
  output logic [VEC_ADDRW:0]            mvm_vec_num_words,
  output logic [MAT_ADDRW-1:0]          mvm_mat_start_addr,
  output logic [MAT_ADDRW:0]            mvm_mat_num_rows,
  input  logic                          mvm_busy,
  input  logic [OWIDTH-1:0]             mvm_result [NUM_OLANES],
  input  logic                          mvm_valid,
`ifdef MVM_DRV_PERF_EN
  output logic [31:0]                   perf_cycles,
`endif
  output logic                          busy,
  output logic                          overflow
);

  localparam int LANE_W = $clog2(NUM_OLANES);
  localparam int PRODW  = VEC_ADDRW + MAT_ADDRW + 2;
  localparam logic [VEC_ADDRW:0] VEC_MAX = {1'b1, {VEC_ADDRW{1'b0}}};
  localparam logic [PRODW-1:0]   MAT_MAX = PRODW'(1) << MAT_ADDRW;

  typedef logic [NUM_OLANES-1:0][OWIDTH-1:0] set_t;

  state_e                 state_q;
  logic [VEC_ADDRW:0]     v_q;
  logic [MAT_ADDRW:0]     r_cfg_q, set_cnt_q, set_cnt_nxt;
  logic [VEC_ADDRW-1:0]   w_q;
  logic [MAT_ADDRW-1:0]   r_q, addr_q;
  logic [LANE_W-1:0]      l_q, lane_q;
  logic                   cfg_ready_q, cfg_err_q, overflow_q, mvm_start_q;
  logic                   vec_wen_q;
  logic [VEC_ADDRW-1:0]   vec_waddr_q;
  logic [MEM_DATAW-1:0]   vec_wdata_q, mat_wdata_q;
  logic [MAT_ADDRW-1:0]   mat_waddr_q;
  logic [NUM_OLANES-1:0]  mat_wen_q;
  logic [PRODW-1:0]       rv_prod;
  logic                   cfg_ok, w_last, r_last, l_last;
  set_t                   push_set, head_set;
  logic                   res_full, res_empty, res_drop, beat, pop;

  assign rv_prod = PRODW'(cfg_vec_words) * PRODW'(cfg_mat_rows);
  assign cfg_ok  = (cfg_vec_words != '0) && (cfg_mat_rows != '0) &&
                   (cfg_vec_words <= VEC_MAX) && (rv_prod <= MAT_MAX);
  assign w_last  = ({1'b0, w_q} == v_q - 1'b1);
  assign r_last  = ({1'b0, r_q} == r_cfg_q - 1'b1);
  assign l_last  = (l_q == LANE_W'(NUM_OLANES - 1));
  assign set_cnt_nxt = set_cnt_q + 1'b1;

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign s_ready   = (state_q == S_LOAD_VEC) || (state_q == S_LOAD_MAT);
  assign busy      = (state_q != S_IDLE);
  assign overflow  = overflow_q;
  assign vec_wen   = vec_wen_q;
  assign vec_waddr = vec_waddr_q;
  assign vec_wdata = vec_wdata_q;
  assign mat_wen   = mat_wen_q;
  assign mat_waddr = mat_waddr_q;
  assign mat_wdata = mat_wdata_q;
  assign mvm_start          = mvm_start_q;
  assign mvm_vec_start_addr = '0;
  assign mvm_mat_start_addr = '0;
  assign mvm_vec_num_words  = v_q;
  assign mvm_mat_num_rows   = r_cfg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      overflow_q  <= 1'b0;
      mvm_start_q <= 1'b0;
      v_q         <= '0;
      r_cfg_q     <= '0;
      set_cnt_q   <= '0;
      w_q         <= '0;
      r_q         <= '0;
      l_q         <= '0;
      addr_q      <= '0;
      vec_wen_q   <= 1'b0;
      vec_waddr_q <= '0;
      vec_wdata_q <= '0;
      mat_wen_q   <= '0;
      mat_waddr_q <= '0;
      mat_wdata_q <= '0;
    end else begin
      vec_wen_q   <= 1'b0;
      mat_wen_q   <= '0;
      mvm_start_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      if (res_drop) overflow_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          cfg_ready_q <= 1'b1;
          if (cfg_valid && cfg_ready_q) begin
            if (cfg_ok) begin
              v_q         <= cfg_vec_words;
              r_cfg_q     <= cfg_mat_rows;
              overflow_q  <= 1'b0;
              cfg_ready_q <= 1'b0;
              w_q         <= '0;
              state_q     <= S_LOAD_VEC;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        S_LOAD_VEC: begin
          if (s_valid) begin
            vec_wen_q   <= 1'b1;
            vec_waddr_q <= w_q;
            vec_wdata_q <= s_data;
            if (w_last) begin
              w_q     <= '0;
              r_q     <= '0;
              l_q     <= '0;
              addr_q  <= '0;
              state_q <= S_LOAD_MAT;
            end else begin
              w_q <= w_q + 1'b1;
            end
          end
        end
        // Lane outer, row, word inner; addr_q tracks r*V+w incrementally.
        S_LOAD_MAT: begin
          if (s_valid) begin
            mat_wen_q   <= NUM_OLANES'(1) << l_q;
            mat_waddr_q <= addr_q;
            mat_wdata_q <= s_data;
            if (w_last) begin
              w_q <= '0;
              if (r_last) begin
                r_q    <= '0;
                addr_q <= '0;
                if (l_last) state_q <= S_KICK;
                else        l_q     <= l_q + 1'b1;
              end else begin
                r_q    <= r_q + 1'b1;
                addr_q <= addr_q + 1'b1;
              end
            end else begin
              w_q    <= w_q + 1'b1;
              addr_q <= addr_q + 1'b1;
            end
          end
        end
        S_KICK: begin
          mvm_start_q <= 1'b1;
          set_cnt_q   <= '0;
          state_q     <= S_RUN;
        end
        S_RUN: begin
          if (mvm_valid) set_cnt_q <= set_cnt_nxt;
          if ((set_cnt_q == r_cfg_q) && !mvm_busy && res_empty) begin
            cfg_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    push_set = '0;
    for (int i = 0; i < NUM_OLANES; i++) push_set[i] = mvm_result[i];
  end

  mvm_drv_resbuf #(
    .DEPTH (RES_DEPTH),
    .set_t (set_t)
  ) u_resbuf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (mvm_valid),
    .push_data_i (push_set),
    .pop_i       (pop),
    .head_o      (head_set),
    .full_o      (res_full),
    .empty_o     (res_empty),
    .drop_o      (res_drop)
  );

  // Drain: head entry goes out one lane per accepted beat, popped on the last lane.
  assign m_valid  = !res_empty;
  assign m_lane   = lane_q;
  assign m_last   = m_valid && (lane_q == LANE_W'(NUM_OLANES - 1));
  assign m_result = m_valid ? head_set[lane_q] : '0;
  assign beat     = m_valid && m_ready;
  assign pop      = beat && m_last;

  always_ff @(posedge clk) begin
    if (rst)       lane_q <= '0;
    else if (beat) lane_q <= m_last ? '0 : lane_q + 1'b1;
  end

`ifdef MVM_DRV_PERF_EN
  logic [31:0] perf_q;
  logic        perf_run_q;

  assign perf_cycles = perf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q     <= '0;
      perf_run_q <= 1'b0;
    end else if (state_q == S_KICK) begin
      perf_q     <= '0;
      perf_run_q <= 1'b1;
    end else if (perf_run_q) begin
      if ((state_q == S_RUN) && mvm_valid && (set_cnt_nxt == r_cfg_q)) perf_run_q <= 1'b0;
      else perf_q <= sat_inc32(perf_q);
    end
  end
`endif

endmodule

// File: tb/tb_mvm_driver.sv
// Directed bench for mvm_driver: config table, load/run/drain sequences, stall, overflow, reset abort.
module tb_mvm_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_ready, cfg_err;
  logic [8:0]  cfg_vec_words;
  logic [9:0]  cfg_mat_rows;
  logic [63:0] s_data;
  logic        s_valid, s_ready;
  logic [31:0] m_result;
  logic [2:0]  m_lane;
  logic        m_last, m_valid, m_ready;
  logic [63:0] vec_wdata, mat_wdata;
  logic [7:0]  vec_waddr;
  logic        vec_wen;
  logic [8:0]  mat_waddr;
  logic [7:0]  mat_wen;
  logic        mvm_start;
  logic [7:0]  mvm_vec_start_addr;
  logic [8:0]  mvm_vec_num_words;
  logic [8:0]  mvm_mat_start_addr;
  logic [9:0]  mvm_mat_num_rows;
  logic        mvm_busy;
  logic [31:0] mvm_result [8];
  logic        mvm_valid;
  logic        busy, overflow;
`ifdef MVM_DRV_PERF_EN
  logic [31:0] perf_cycles;
`endif

  mvm_driver dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_vec_words(cfg_vec_words), .cfg_mat_rows(cfg_mat_rows), .cfg_err(cfg_err),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_result(m_result), .m_lane(m_lane), .m_last(m_last), .m_valid(m_valid), .m_ready(m_ready),
    .vec_wdata(vec_wdata), .vec_waddr(vec_waddr), .vec_wen(vec_wen),
    .mat_wdata(mat_wdata), .mat_waddr(mat_waddr), .mat_wen(mat_wen),
    .mvm_start(mvm_start),
    .mvm_vec_start_addr(mvm_vec_start_addr), .mvm_vec_num_words(mvm_vec_num_words),
    .mvm_mat_start_addr(mvm_mat_start_addr), .mvm_mat_num_rows(mvm_mat_num_rows),
    .mvm_busy(mvm_busy), .mvm_result(mvm_result), .mvm_valid(mvm_valid),
`ifdef MVM_DRV_PERF_EN
    .perf_cycles(perf_cycles),
`endif
    .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [71:0]  vec_q[$];
  logic [80:0]  mat_q[$];
  logic [35:0]  beat_q[$];
  logic [35:0]  exp_beat_q[$];
  int           start_cnt, start_cyc, last_mat_cyc, last_valid_cyc;
  logic [35:0]  start_fields;
  logic         stall_prev = 1'b0;
  logic [36:0]  prev_m;
  bit           stop;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Passive monitor: records writes, start pulses and accepted beats; checks stall stability.
  always @(negedge clk) begin
    if (!rst) begin
      if (vec_wen) vec_q.push_back({vec_waddr, vec_wdata});
      if (|mat_wen) begin
        mat_q.push_back({mat_wen, mat_waddr, mat_wdata});
        last_mat_cyc = cyc;
      end
      if (mvm_start) begin
        start_cnt++;
        start_cyc = cyc;
        start_fields = {mvm_vec_start_addr, mvm_vec_num_words, mvm_mat_start_addr, mvm_mat_num_rows};
      end
      if (m_valid && m_ready) beat_q.push_back({m_last, m_lane, m_result});
      if (stall_prev) chk("stall_hold", {91'd0, m_valid, m_last, m_lane, m_result}, {91'd0, prev_m});
      stall_prev = m_valid && !m_ready;
      prev_m = {m_valid, m_last, m_lane, m_result};
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wd(input int run, input int i);
    return {16'hD00D, 16'(run), 32'(i)};
  endfunction

  function automatic logic [31:0] rv(input int run, input int s, input int j);
    logic [7:0] sb;
    sb = 8'(s);
    return {sb[0], 7'(run), sb, 8'h00, 8'(j + 1)};
  endfunction

  task automatic do_reset();
    rst = 1'b1; cfg_valid = 1'b0; s_valid = 1'b0; mvm_valid = 1'b0; mvm_busy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic clear_mon();
    vec_q.delete(); mat_q.delete(); beat_q.delete(); exp_beat_q.delete();
    start_cnt = 0;
  endtask

  task automatic send_cfg(input int v, input int r);
    cfg_vec_words = 9'(v);
    cfg_mat_rows  = 10'(r);
    for (int i = 0; i < 50 && !cfg_ready; i++) tick();
    if (!cfg_ready) chk("cfg_ready_timeout", 0, 1);
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic stream(input int run, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      s_valid = 1'b1;
      s_data  = wd(run, i);
      for (int t = 0; t < 100 && !s_ready; t++) tick();
      if (!s_ready) begin
        chk("s_ready_timeout", 0, 1);
        break;
      end
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic engine(input int run, input int r, input int lat, input int keep, input bit ovf_chk);
    for (int t = 0; t < 200 && !mvm_start; t++) tick();
    if (!mvm_start) chk("start_timeout", 0, 1);
    mvm_busy = 1'b1;
    for (int s = 0; s < r; s++) begin
      repeat (lat) tick();
      for (int j = 0; j < 8; j++) begin
        mvm_result[j] = rv(run, s, j);
        if (s < keep) exp_beat_q.push_back({(j == 7), 3'(j), rv(run, s, j)});
      end
      mvm_valid = 1'b1;
      last_valid_cyc = cyc;
      tick();
      mvm_valid = 1'b0;
      if (ovf_chk && s == keep - 1) chk("ovf_before_drop", {127'd0, overflow}, 0);
      if (ovf_chk && s == keep)     chk("ovf_after_drop", {127'd0, overflow}, 1);
    end
    mvm_busy = 1'b0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 2000 && busy; t++) tick();
    chk("return_idle", {127'd0, busy}, 0);
  endtask

  task automatic check_run(input int run, input int v, input int r);
    int idx;
    chk("vec_count", vec_q.size(), v);
    for (int k = 0; k < v && k < vec_q.size(); k++)
      chk("vec_write", vec_q[k], {8'(k), wd(run, k)});
    chk("mat_count", mat_q.size(), 8 * r * v);
    idx = 0;
    for (int l = 0; l < 8; l++)
      for (int rr = 0; rr < r; rr++)
        for (int w = 0; w < v; w++) begin
          if (idx < mat_q.size())
            chk("mat_write", mat_q[idx], {8'(1 << l), 9'(rr * v + w), wd(run, v + idx)});
          idx++;
        end
    chk("start_count", start_cnt, 1);
    chk("start_after_last_wen", start_cyc, last_mat_cyc + 1);
    chk("run_fields", start_fields, {8'd0, 9'(v), 9'd0, 10'(r)});
    chk("beat_count", beat_q.size(), exp_beat_q.size());
    for (int b = 0; b < beat_q.size() && b < exp_beat_q.size(); b++)
      chk("result_beat", beat_q[b], exp_beat_q[b]);
  endtask

  typedef struct {
    int v;
    int r;
    bit exp_err;
    bit exp_busy;
  } cfg_vec_t;
  cfg_vec_t tbl[7];

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    mvm_busy = 1'b0; mvm_valid = 1'b0; cfg_vec_words = '0; cfg_mat_rows = '0;
    for (int j = 0; j < 8; j++) mvm_result[j] = '0;

    tbl[0] = '{0, 1, 1'b1, 1'b0};
    tbl[1] = '{2, 300, 1'b1, 1'b0};
    tbl[2] = '{257, 1, 1'b1, 1'b0};
    tbl[3] = '{1, 0, 1'b1, 1'b0};
    tbl[4] = '{2, 257, 1'b1, 1'b0};
    tbl[5] = '{256, 2, 1'b0, 1'b1};
    tbl[6] = '{2, 256, 1'b0, 1'b1};

    tick();
    chk("reset_ctrl", {cfg_ready, cfg_err, s_ready, m_valid, m_last, busy, overflow, mvm_start, vec_wen, mat_wen},
        0);
    chk("reset_fields", {m_result, mvm_vec_num_words, mvm_mat_num_rows}, 0);
    rst = 1'b0;
    tick();

    // Configuration table: illegal ones pulse cfg_err; legal boundary ones start and are aborted.
    for (int i = 0; i < 7; i++) begin
      clear_mon();
      send_cfg(tbl[i].v, tbl[i].r);
      chk($sformatf("cfg_err[%0d]", i), {127'd0, cfg_err}, {127'd0, tbl[i].exp_err});
      chk($sformatf("cfg_busy[%0d]", i), {127'd0, busy}, {127'd0, tbl[i].exp_busy});
      tick();
      chk($sformatf("cfg_err_pulse[%0d]", i), {127'd0, cfg_err}, 0);
      if (tbl[i].exp_busy) do_reset();
      chk($sformatf("cfg_no_writes[%0d]", i), vec_q.size() + mat_q.size(), 0);
    end

    // Basic run V=2 R=1, back-to-back load, results 1..8.
    clear_mon();
    m_ready = 1'b1;
    send_cfg(2, 1);
    stream(0, 18, 1'b0);
    engine(0, 1, 3, 1, 1'b0);
    wait_idle();
    check_run(0, 2, 1);
    if (mat_q.size() > 7) chk("lane3_first", mat_q[6], {8'h08, 9'd0, wd(0, 8)});

    // Backpressure: six sets with m_ready low, four buffered, overflow on the fifth.
    clear_mon();
    m_ready = 1'b0;
    send_cfg(1, 6);
    chk("ovf_cleared_by_cfg", {127'd0, overflow}, 0);
    stream(3, 49, 1'b0);
    engine(3, 6, 2, 4, 1'b1);
    chk("ovf_sticky", {127'd0, overflow}, 1);
    chk("busy_while_full", {127'd0, busy}, 1);
    repeat (3) tick();
    m_ready = 1'b1;
    wait_idle();
    check_run(3, 1, 6);
    chk("ovf_after_idle", {127'd0, overflow}, 1);

    // Random stream gaps and result stalls, V=4 R=2.
    clear_mon();
    send_cfg(4, 2);
    chk("ovf_cleared_again", {127'd0, overflow}, 0);
    stop = 1'b0;
    fork
      begin
        stream(4, 68, 1'b1);
        engine(4, 2, 5, 2, 1'b0);
        wait_idle();
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          m_ready = 1'($urandom_range(0, 1));
          tick();
        end
        m_ready = 1'b1;
      end
    join
    check_run(4, 4, 2);

    // Reset in the middle of the matrix load, then a clean run.
    clear_mon();
    send_cfg(2, 1);
    stream(5, 7, 1'b0);
    chk("in_load_mat", {127'd0, s_ready}, 1);
    rst = 1'b1;
    tick();
    chk("abort_ctrl", {cfg_ready, cfg_err, s_ready, m_valid, m_last, m_lane, m_result, busy, overflow, mvm_start,
                       vec_wen, vec_waddr, mat_wen, mat_waddr, mvm_vec_num_words, mvm_mat_num_rows}, 0);
    chk("abort_wdata", {vec_wdata, mat_wdata}, 0);
    rst = 1'b0;
    tick();
    clear_mon();
    send_cfg(2, 1);
    stream(6, 18, 1'b0);
    engine(6, 1, 3, 1, 1'b0);
    wait_idle();
    check_run(6, 2, 1);

`ifdef MVM_DRV_PERF_EN
    // Perf counter: latency 10 per set, R=2; start cycle to second capture is 21 cycles.
    clear_mon();
    send_cfg(1, 2);
    stream(7, 17, 1'b0);
    engine(7, 2, 10, 2, 1'b0);
    wait_idle();
    chk("perf_gap", perf_cycles, 32'(last_valid_cyc - start_cyc));
    chk("perf_value", perf_cycles, 32'd21);
    repeat (5) tick();
    chk("perf_hold", perf_cycles, 32'd21);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mvm_driver.md
Name: mvm_driver

Overview:
- Host-side initiator for the matrix-vector multiply engine.
- Accepts a run configuration and one streamed input of packed words, then writes the vector memory and the per-lane matrix memories through the engine's write ports.
- Issues a one-cycle start pulse and captures every result set the engine produces.
- Serializes the captured result sets onto a valid/ready output stream, one lane result per beat.

Parameters:
- IWIDTH, 8, element width packed in memory words
- OWIDTH, 32, engine result width per lane
- MEM_DATAW, IWIDTH*8, memory word width
- VEC_ADDRW, 8, vector memory address width
- MAT_ADDRW, 9, matrix memory address width
- NUM_OLANES, 8, engine output lanes
- RES_DEPTH, 4, result-set buffer entries (power of 2)

Ports:
- clk  in  1  clock
- rst  in  1  reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted when high with cfg_valid
- cfg_vec_words  in  VEC_ADDRW+1  V, number of vector words
- cfg_mat_rows  in  MAT_ADDRW+1  R, rows per lane
- cfg_err  out  1  one-cycle pulse: configuration rejected
- s_data  in  MEM_DATAW  load stream data
- s_valid  in  1  load stream valid
- s_ready  out  1  load stream ready
- m_result  out  OWIDTH  result beat
- m_lane  out  $clog2(NUM_OLANES)  lane index of beat
- m_last  out  1  final lane of a result set
- m_valid  out  1  result beat valid
- m_ready  in  1  result beat accepted
- vec_wdata/vec_waddr/vec_wen  out  MEM_DATAW/VEC_ADDRW/1  engine vector write port
- mat_wdata/mat_waddr/mat_wen  out  MEM_DATAW/MAT_ADDRW/NUM_OLANES  engine matrix write port, one-hot wen
- mvm_start  out  1  engine start pulse
- mvm_vec_start_addr, mvm_vec_num_words, mvm_mat_start_addr, mvm_mat_num_rows  out  engine widths  run fields
- mvm_busy  in  1  engine busy
- mvm_result  in  OWIDTH x NUM_OLANES (unpacked)  engine results
- mvm_valid  in  1  engine result set valid
- busy  out  1  driver not IDLE
- overflow  out  1  sticky: a result set was dropped

Behaviour:
- Reset:
  - Reset rst is synchronous and active-high; clock is clk.
  - All outputs are 0 and the FSM is IDLE.
  - The result buffer is emptied and the lane counter cleared.
  - Reset mid-operation aborts the run and discards buffered results.
- States: IDLE, LOAD_VEC, LOAD_MAT, KICK, RUN.
- IDLE:
  - cfg_ready=1.
  - On handshake with V>=1, R>=1 and R*V<=2^MAT_ADDRW: latch V and R, clear overflow, go to LOAD_VEC.
  - Otherwise pulse cfg_err for one cycle and stay in IDLE.
  - V > 2^VEC_ADDRW is also an error.
- LOAD_VEC:
  - s_ready=1.
  - Word k (0..V-1) is written to vec_waddr=k. The write-port signals are registered, so vec_wen asserts on the cycle after the handshake.
  - After word V-1, go to LOAD_MAT.
- LOAD_MAT:
  - Loop order: lane l outer, row r, then word w inner.
  - Writes go to mat_waddr=r*V+w with mat_wen=1<<l.
  - Uses an address counter, no multiplier.
  - Total words: NUM_OLANES*R*V.
  - After the final word, go to KICK.
- KICK:
  - Entered one cycle after the final write enable.
  - mvm_start=1 for exactly one cycle.
  - Run fields are driven continuously from latched config: vector start address 0, matrix start address 0, V, R.
  - Next state: RUN.
- RUN:
  - Counts mvm_valid pulses.
  - Returns to IDLE once R sets have been received, mvm_busy=0 and the buffer is empty.
- Capture:
  - Every mvm_valid pushes all NUM_OLANES results as one entry, in any state.
  - If the buffer is full, the set is dropped, overflow is set, and the set still counts toward R. The engine has no backpressure.
- Drain:
  - The head entry is emitted as lane 0..NUM_OLANES-1.
  - m_last=1 on lane NUM_OLANES-1. The lane counter advances on m_valid&m_ready.
  - The entry is popped with the last beat.
  - Outputs stay stable while m_valid&!m_ready.
  - Simultaneous push and pop when full is allowed: the pop frees the slot, no drop.
- Result beats are the raw OWIDTH values, not re-signed.

Optional Feature:
- MVM_DRV_PERF_EN defined: adds output perf_cycles (32 bits).
  - Cleared on the KICK cycle, increments every cycle after it.
  - Freezes on capture of set R.
  - Holds until the next KICK and saturates at all-ones.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mvm_drv_pkg holds:
  - the FSM state enum;
  - the result-set typedef (array of NUM_OLANES OWIDTH words);
  - the derived width localparams.
- Sub-module mvm_drv_resbuf: the RES_DEPTH result-set FIFO with full/empty, push, and pop plus drop signalling.
- The FSM and address generation stay in mvm_driver.

Test Plan:
1. V=2, R=1, with 2+8*2=18 load words streamed back-to-back:
   - vec writes land at addr 0,1;
   - lane 3 gets mat_waddr 0,1 with mat_wen=8'h08;
   - mvm_start pulses once.
   - Model mvm_valid with results 1..8 → 8 beats, m_lane 0..7, m_last on beat 8.
2. Illegal configs: cfg V=0, then R=300 with V=2 (600 > 512) → cfg_err pulses each time, busy stays 0, no writes.
3. m_ready held 0 with R=6 sets arriving → 4 sets buffered, overflow=1 after set 5. Then release m_ready → 32 beats, then IDLE.
4. Random s_valid and m_ready gaps, V=4, R=2 → every write and result beat is correct and in order. m_* stay stable during stalls.
5. rst asserted mid LOAD_MAT → next cycle all outputs 0. A new config then runs cleanly.
6. With MVM_DRV_PERF_EN and a model latency of 10 cycles per set, R=2 → perf_cycles equals the gap from KICK to capture of set 2.
